// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, plus a shift-add
// unsigned multiplier and a restoring unsigned divider that each produce one
// bit per clock. The multiplier and divider share one pair of shift registers.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1010;

    localparam int               CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;         // multiplicand
    logic [WIDTH-1:0] b_q, b_d;         // divisor
    logic [WIDTH-1:0] hw_q, hw_d;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hw, mul_lo;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub, div_hw, div_lo;

    // Single-cycle result, computed straight from the operands being accepted.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first so
        // no path leaves it unassigned; otherwise synthesis infers a latch.
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a + ~b + ONE;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift {carry, hw, lo} right by one.
        mul_addend = lo_q[0] ? a_q : '0;
        mul_sum    = {1'b0, hw_q} + {1'b0, mul_addend};
        mul_hw     = mul_sum[WIDTH:1];
        mul_lo     = {mul_sum[0], lo_q[WIDTH-1:1]};
        // Divide: bring in the next dividend bit, subtract if it fits. With a
        // zero divisor every trial fits, so the quotient becomes all ones and
        // the remainder ends up equal to the dividend.
        div_shift  = {hw_q, lo_q[WIDTH-1]};
        div_ge     = div_shift >= {1'b0, b_q};
        div_sub    = div_shift[WIDTH-1:0] - b_q;
        div_hw     = div_ge ? div_sub : div_shift[WIDTH-1:0];
        div_lo     = {lo_q[WIDTH-2:0], div_ge};
    end

    // Next-state logic for the FSM, datapath registers and output registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        hw_d     = hw_q;
        lo_d     = lo_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    cnt_d = '0;
                    hw_d  = '0;
                    if (op == OP_MULTU) begin
                        state_d = S_MUL;
                        lo_d    = b;
                    end else if (op == OP_DIVU) begin
                        state_d = S_DIV;
                        lo_d    = a;
                    end else begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        hi_d     = '0;
                        zero_d   = (alu_res == '0);
                        dbz_d    = 1'b0;
                    end
                end
            end
            S_MUL: begin
                hw_d  = mul_hw;
                lo_d  = mul_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    result_d = mul_lo;
                    hi_d     = mul_hw;
                    zero_d   = (mul_lo == '0);
                    dbz_d    = 1'b0;
                end
            end
            S_DIV: begin
                hw_d  = div_hw;
                lo_d  = div_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    result_d = div_lo;
                    hi_d     = div_hw;
                    zero_d   = (div_lo == '0);
                    dbz_d    = (b_q == '0);
                end
            end
            default: state_d = S_IDLE;   // S_DONE lasts exactly one cycle
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hw_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so all registers
            // update together from pre-edge values; comb blocks use blocking.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hw_q     <= hw_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit instance driven from a vector table plus
// hand-written sequences (mid-op start pulses, reset abort), and an 8-bit
// instance for the narrow multi-cycle cases.
module tb_alu_mc;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam int         MAX_WAIT = 100;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        dbz;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, start8;
    logic [3:0]  op, op8;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic        busy, done, zero, div_by_zero;
    logic        busy8, done8, zero8, div_by_zero8;
    logic [31:0] result, hi;
    logic [7:0]  result8, hi8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .hi(hi),
        .zero(zero), .div_by_zero(div_by_zero)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .hi(hi8),
        .zero(zero8), .div_by_zero(div_by_zero8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] r, input logic [31:0] h,
                                input logic z, input logic d, input int l);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.res = r; v.hi = h; v.z = z; v.dbz = d; v.lat = l;
        return v;
    endfunction

    // Issue one op on the 32-bit instance; scramble inputs after acceptance,
    // wait (bounded) for done, then step into the following idle cycle.
    task automatic run32(input string name, input logic [3:0] o, input logic [31:0] va,
                         input logic [31:0] vb, output int lat, output logic [31:0] r,
                         output logic [31:0] h, output logic z, output logic d);
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = o ^ 4'b0101; a = ~va; b = ~vb;
        check({name, ".busy"}, 64'(busy), 64'd1);
        lat = 1;
        while (!done && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result; h = hi; z = zero; d = div_by_zero;
        @(posedge clk);
        #1;
        check({name, ".idle"}, 64'({busy, done}), 64'd0);
    endtask

    task automatic run8(input string name, input logic [3:0] o, input logic [7:0] va,
                        input logic [7:0] vb, input logic [7:0] er, input logic [7:0] eh,
                        input logic ed);
        int lat;
        @(negedge clk);
        op8 = o; a8 = va; b8 = vb; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
        lat = 1;
        while (!done8 && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, ".lat"}, 64'(lat), 64'd9);
        check({name, ".result"}, 64'(result8), 64'(er));
        check({name, ".hi"}, 64'(hi8), 64'(eh));
        check({name, ".dbz"}, 64'(div_by_zero8), 64'(ed));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[$];
        int          lat, pulses;
        logic [31:0] r, h;
        logic        z, d;

        vecs.push_back(mk(OP_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_AND,   32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 32'd0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_OR,    32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 32'd0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_ADD,   32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 32'd0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SUB,   32'd7,         32'd7,         32'd0,         32'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_SLT,   32'h8000_0000, 32'd1,         32'd1,         32'd0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SLTU,  32'h8000_0000, 32'd1,         32'd0,         32'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_SLT,   32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         32'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_SLT,   32'hFFFF_FFFF, 32'd0,         32'd1,         32'd0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SLTU,  32'd1,         32'h8000_0000, 32'd1,         32'd0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'b0101,  32'd5,         32'd3,         32'd0,         32'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33));
        vecs.push_back(mk(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1, 1'b1, 1'b0, 33));
        vecs.push_back(mk(OP_MULTU, 32'd12345,     32'd0,         32'd0,         32'd0, 1'b1, 1'b0, 33));
        vecs.push_back(mk(OP_DIVU,  32'd100,       32'd7,         32'd14,        32'd2, 1'b0, 1'b0, 33));
        vecs.push_back(mk(OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 33));
        vecs.push_back(mk(OP_ADD,   32'd2,         32'd3,         32'd5,         32'd0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33));
        vecs.push_back(mk(OP_DIVU,  32'd3,         32'd10,        32'd0,         32'd3, 1'b1, 1'b0, 33));
        vecs.push_back(mk(OP_DIVU,  32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 33));

        reset_n = 1'b0;
        start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #12;
        check("reset.ctrl", 64'({busy, done, zero, div_by_zero}), 64'd0);
        check("reset.result", 64'(result), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);

        // First rising edge with reset released accepts the request.
        @(negedge clk);
        reset_n = 1'b1;
        op = OP_OR; a = 32'h0000_0F00; b = 32'h0000_000F; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("first_start.done", 64'(done), 64'd1);
        check("first_start.result", 64'(result), 64'h0000_0F0F);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run32(nm, vecs[i].op, vecs[i].a, vecs[i].b, lat, r, h, z, d);
            check({nm, ".lat"}, 64'(lat), 64'(vecs[i].lat));
            check({nm, ".result"}, 64'(r), 64'(vecs[i].res));
            check({nm, ".hi"}, 64'(h), 64'(vecs[i].hi));
            check({nm, ".zero"}, 64'(z), 64'(vecs[i].z));
            check({nm, ".dbz"}, 64'(d), 64'(vecs[i].dbz));
        end

        // multu with start held high (different op/operands) the whole time.
        @(negedge clk);
        op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        #1;
        op = OP_ADD; a = 32'd1; b = 32'd1;
        lat = 1;
        while (!done && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("busy_start.lat", 64'(lat), 64'd33);
        check("busy_start.result", 64'(result), 64'h0000_0001);
        check("busy_start.hi", 64'(hi), 64'hFFFF_FFFE);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("busy_start.no_queue", 64'(pulses), 64'd0);

        // Reset in cycle 10 of a multu aborts it and clears outputs at once.
        @(negedge clk);
        op = OP_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort.ctrl", 64'({busy, done, zero, div_by_zero}), 64'd0);
        check("abort.result", 64'(result), 64'd0);
        check("abort.hi", 64'(hi), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("abort.no_done", 64'(pulses), 64'd0);
        run32("after_abort", OP_OR, 32'h0000_00F0, 32'h0000_000F, lat, r, h, z, d);
        check("after_abort.lat", 64'(lat), 64'd1);
        check("after_abort.result", 64'(r), 64'h0000_00FF);

        run8("w8_multu", OP_MULTU, 8'hFF, 8'h02, 8'hFE, 8'h01, 1'b0);
        run8("w8_divu", OP_DIVU, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run8("w8_div0", OP_DIVU, 8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
